tri_wave_phase_gen: RTL and testbench

Phase-accumulator address generator feeding the 1024x8 triangular-wave ROM upstream of the AD9708 DAC path. It produces the ROM address stream from a frequency tuning word with a programmable phase offset. It supports continuous or burst (N-period) output and glitch-free frequency updates. It also emits a data-valid strobe aligned to the ROM read latency.

---
 rtl/tri_wave_phase_gen.sv | 153 +++++++++++++++
 tb/tb_tri_wave_phase_gen.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/tri_wave_phase_gen.sv
// Phase-accumulator ROM address generator for the triangular-wave DAC path.
// Continuous or N-period burst output, phase offset, wrap-synchronous FTW updates.
module tri_wave_phase_gen #(
  parameter int ACC_WIDTH   = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int CNT_WIDTH   = 16,
  parameter int ROM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  abort,
  input  logic                  burst_mode,
  input  logic [CNT_WIDTH-1:0]  burst_cycles,
  input  logic [ACC_WIDTH-1:0]  ftw_in,
  input  logic                  ftw_load,
  input  logic [ADDR_WIDTH-1:0] phase_off,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  addr_vld,
  output logic                  data_vld,
  output logic                  wrap,
  output logic                  busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP_PEND} state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [ACC_WIDTH-1:0]    r_acc;
  logic [ACC_WIDTH-1:0]    r_ftw_active;
  logic [ACC_WIDTH-1:0]    r_ftw_pend;
  logic                    r_pend_flag;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [ADDR_WIDTH-1:0]   r_off;
  logic                    r_addr_vld;
  logic                    r_wrap;
  logic                    r_mode;
  logic [CNT_WIDTH-1:0]    r_limit;
  logic [CNT_WIDTH-1:0]    r_cnt;
  logic [ROM_LATENCY-1:0]  r_vld_pipe;

  logic [ACC_WIDTH:0]      w_acc_sum;
  logic [ACC_WIDTH-1:0]    w_acc_next;
  logic                    w_carry;
  logic [ADDR_WIDTH-1:0]   w_addr_next;
  logic [CNT_WIDTH-1:0]    w_cnt_inc;
  logic                    w_burst_end;
  logic                    w_ftw_copy;
  logic                    w_launch;
  logic                    w_end;
  logic                    w_step;

  assign w_acc_sum   = {1'b0, r_acc} + {1'b0, r_ftw_active};
  assign w_acc_next  = w_acc_sum[ACC_WIDTH-1:0];
  assign w_carry     = w_acc_sum[ACC_WIDTH];
  assign w_addr_next = w_acc_next[ACC_WIDTH-1 -: ADDR_WIDTH] + r_off;
  assign w_cnt_inc   = r_cnt + 1'b1;
  assign w_burst_end = r_mode && (r_limit != '0) && w_carry && (w_cnt_inc == r_limit);
  // A pending word goes live at once when idle, otherwise only on an overflow.
  assign w_ftw_copy  = r_pend_flag && ((r_state == S_IDLE) || w_carry);

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_launch     = 1'b0;
    w_end        = 1'b0;
    w_step       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_launch     = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN, S_STOP_PEND: begin
        if (abort || w_burst_end || ((r_state == S_STOP_PEND) && w_carry)) begin
          w_end        = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_step = 1'b1;
          if ((r_state == S_RUN) && stop) w_state_next = S_STOP_PEND;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ftw_active <= '0;
      r_ftw_pend   <= '0;
      r_pend_flag  <= 1'b0;
    end else begin
      if (w_ftw_copy) r_ftw_active <= r_ftw_pend;
      if (ftw_load)   r_ftw_pend   <= ftw_in;
      r_pend_flag <= ftw_load || (r_pend_flag && !w_ftw_copy);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc      <= '0;
      r_addr     <= '0;
      r_off      <= '0;
      r_addr_vld <= 1'b0;
      r_wrap     <= 1'b0;
      r_mode     <= 1'b0;
      r_limit    <= '0;
      r_cnt      <= '0;
    end else if (w_launch) begin
      r_acc      <= '0;
      r_addr     <= phase_off;
      r_off      <= phase_off;
      r_addr_vld <= 1'b1;
      r_wrap     <= 1'b0;
      r_mode     <= burst_mode;
      r_limit    <= burst_cycles;
      r_cnt      <= '0;
    end else if (w_step) begin
      r_acc  <= w_acc_next;
      r_addr <= w_addr_next;
      r_wrap <= w_carry;
      if (w_carry) r_cnt <= w_cnt_inc;
    end else begin
      // Terminating or idle: the final wrapped sample is suppressed, addr holds.
      r_addr_vld <= r_addr_vld && !w_end;
      r_wrap     <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_pipe <= '0;
    end else begin
      r_vld_pipe[0] <= r_addr_vld;
      for (int i = 1; i < ROM_LATENCY; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
    end
  end

  assign addr     = r_addr;
  assign addr_vld = r_addr_vld;
  assign wrap     = r_wrap;
  assign data_vld = r_vld_pipe[ROM_LATENCY-1];
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_tri_wave_phase_gen.sv
// Scoreboard bench for tri_wave_phase_gen: stimulus queues expected samples,
// a negedge monitor pops one per valid address and tracks data_vld alignment.
module tb_tri_wave_phase_gen;

  localparam int AW  = 32;
  localparam int DW  = 10;
  localparam int CW  = 16;
  localparam int LAT = 1;

  typedef struct packed {
    logic [DW-1:0] addr;
    logic          wrap;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, stop = 1'b0, abort = 1'b0;
  logic          burst_mode = 1'b0;
  logic [CW-1:0] burst_cycles = '0;
  logic [AW-1:0] ftw_in = '0;
  logic          ftw_load = 1'b0;
  logic [DW-1:0] phase_off = '0;
  logic [DW-1:0] addr;
  logic          addr_vld, data_vld, wrap, busy;

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  logic [LAT-1:0] hist = '0;

  tri_wave_phase_gen #(.ACC_WIDTH(AW), .ADDR_WIDTH(DW), .CNT_WIDTH(CW), .ROM_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .abort(abort),
    .burst_mode(burst_mode), .burst_cycles(burst_cycles), .ftw_in(ftw_in),
    .ftw_load(ftw_load), .phase_off(phase_off), .addr(addr), .addr_vld(addr_vld),
    .data_vld(data_vld), .wrap(wrap), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int a, input bit w);
    exp_t e;
    e.addr = DW'(a);
    e.wrap = w;
    sb.push_back(e);
  endtask

  // Monitor: compare each valid sample against the scoreboard head.
  always @(negedge clk) begin
    if (rst) begin
      hist = '0;
    end else begin
      exp_t e;
      check("data_vld_align", {31'd0, data_vld}, {31'd0, hist[LAT-1]});
      if (addr_vld) begin
        if (sb.size() == 0) begin
          check("unexpected_sample", addr, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("addr", {22'd0, addr}, {22'd0, e.addr});
          check("wrap", {31'd0, wrap}, {31'd0, e.wrap});
        end
      end else begin
        check("wrap_idle", {31'd0, wrap}, 32'd0);
      end
      for (int i = LAT - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = addr_vld;
    end
  end

  task automatic load_ftw(input logic [AW-1:0] v);
    @(negedge clk); ftw_in = v; ftw_load = 1'b1;
    @(negedge clk); ftw_load = 1'b0;
    @(negedge clk);
  endtask

  // Returns at the negedge where the first sample (addr = phase_off) is visible.
  task automatic start_gen();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
  endtask

  task automatic drained(input string name);
    check(name, sb.size(), 32'd0);
    sb.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check("rst_addr", {22'd0, addr}, 32'd0);
    check("rst_addr_vld", {31'd0, addr_vld}, 32'd0);
    check("rst_data_vld", {31'd0, data_vld}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); #2 rst = 1'b0;

    // Idle corner cases: stop ignored, start+abort stays idle
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    check("idle_stop_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    check("start_abort_busy", {31'd0, busy}, 32'd0);
    check("start_abort_vld", {31'd0, addr_vld}, 32'd0);

    // T1: step 1, offset 0, one full period plus the wrapped sample
    load_ftw(32'h0040_0000);
    phase_off = '0;
    for (int k = 0; k < 1024; k++) push(k, 1'b0);
    push(0, 1'b1);
    start_gen();
    check("t1_busy", {31'd0, busy}, 32'd1);
    repeat (1024) @(negedge clk);
    pulse_abort();
    check("t1_abort_vld", {31'd0, addr_vld}, 32'd0);
    check("t1_abort_busy", {31'd0, busy}, 32'd0);
    check("t1_addr_hold", {22'd0, addr}, 32'd0);
    drained("t1_drain");

    // T2: offset 1000, wrap follows the accumulator, not addr 0
    phase_off = 10'd1000;
    for (int k = 0; k <= 1024; k++) push((k + 1000) % 1024, k == 1024);
    start_gen();
    repeat (1024) @(negedge clk);
    pulse_abort();
    drained("t2_drain");

    // T3: new FTW loaded at addr 300 takes effect only after the wrap
    phase_off = '0;
    for (int k = 0; k < 1024; k++) push(k, 1'b0);
    push(0, 1'b1);
    for (int j = 1; j <= 6; j++) push(2 * j, 1'b0);
    start_gen();
    repeat (300) @(negedge clk);
    ftw_in = 32'h0080_0000; ftw_load = 1'b1;
    @(negedge clk); ftw_load = 1'b0;
    repeat (1030 - 301) @(negedge clk);
    pulse_abort();
    drained("t3_drain");

    // T4: burst of 3 periods at step 4
    load_ftw(32'h0100_0000);
    burst_mode = 1'b1; burst_cycles = 16'd3;
    for (int k = 0; k < 768; k++) push((4 * k) % 1024, (k == 256) || (k == 512));
    start_gen();
    burst_mode = 1'b0; burst_cycles = '0;
    repeat (780) @(negedge clk);
    check("t4_vld", {31'd0, addr_vld}, 32'd0);
    check("t4_busy", {31'd0, busy}, 32'd0);
    check("t4_addr_hold", {22'd0, addr}, 32'd1020);
    drained("t4_drain");

    // T5a: stop at addr 500 drains to the end of the period
    load_ftw(32'h0040_0000);
    for (int k = 0; k < 1024; k++) push(k, 1'b0);
    start_gen();
    repeat (500) @(negedge clk);
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    check("t5a_busy_pending", {31'd0, busy}, 32'd1);
    repeat (1030 - 501) @(negedge clk);
    check("t5a_vld", {31'd0, addr_vld}, 32'd0);
    check("t5a_busy", {31'd0, busy}, 32'd0);
    check("t5a_addr_hold", {22'd0, addr}, 32'd1023);
    drained("t5a_drain");

    // T5b: abort at addr 500 stops immediately
    for (int k = 0; k <= 500; k++) push(k, 1'b0);
    start_gen();
    repeat (500) @(negedge clk);
    pulse_abort();
    check("t5b_vld", {31'd0, addr_vld}, 32'd0);
    check("t5b_busy", {31'd0, busy}, 32'd0);
    check("t5b_addr_hold", {22'd0, addr}, 32'd500);
    drained("t5b_drain");

    // T6: async reset mid-run, then restart with FTW cleared (addr holds)
    phase_off = 10'd7;
    for (int k = 0; k <= 100; k++) push(7 + k, 1'b0);
    start_gen();
    repeat (100) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_addr", {22'd0, addr}, 32'd0);
    check("t6_rst_vld", {31'd0, addr_vld}, 32'd0);
    check("t6_rst_dvld", {31'd0, data_vld}, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    drained("t6_pre_drain");
    @(negedge clk); #2 rst = 1'b0;
    for (int k = 0; k < 5; k++) push(7, 1'b0);
    start_gen();
    repeat (4) @(negedge clk);
    check("t6_hold_busy", {31'd0, busy}, 32'd1);
    pulse_abort();
    check("t6_end_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    drained("t6_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
